cordic_atan2_16bit: RTL and testbench
=====================================

# cordic_atan2_16bit

Iterative 16-iteration vectoring-mode CORDIC that converts a signed Cartesian vector (x, y) into a 16-bit phase angle and a magnitude. It is the inverse of the team's rotation-mode CORDIC trig block, and uses the same angle encoding (0–65535 = 0–2π), the same arctan constants and the same start/ready/done handshake. Typical uses are phase recovery and polar conversion downstream of sin/cos generation.

## Interface
- No parameters; all widths are fixed.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a conversion; sampled only while the FSM is in IDLE.
- `x_in`  in  16  signed two's-complement x component.
- `y_in`  in  16  signed two's-complement y component.
- `angle`  out  16  phase atan2(y, x); 0–65535 maps to 0–2π, wraps modulo 2^16.
- `magnitude`  out  17  unsigned sqrt(x²+y²); scaling depends on Configuration.
- `done`  out  1  one-cycle pulse when `angle`/`magnitude` are updated.
- `ready`  out  1  high when the block can accept `start`.

## Operation
- FSM states: IDLE → COMPUTE → FINISH → IDLE. Two-bit encoding: IDLE=0, COMPUTE=1, FINISH=2. Unused code 3 returns to IDLE.
- **Reset values:** `angle`=0, `magnitude`=0, `done`=0, `ready`=1; internal state is IDLE, iteration=0.
- **IDLE, on `start`:**
  - Latch the inputs, sign-extended into 19-bit signed working registers X and Y; set `ready`←0.
  - Pre-rotation: if x_in<0, set X←−x, Y←−y, Z←32768 (π). Otherwise set Z←0.
  - Sign extension happens before negation, so −32768 is handled exactly.
- **COMPUTE (iterations i=0..15, one per cycle):**
  - If Y≥0: X←X+(Y>>>i), Y←Y−(X>>>i), Z←Z+atan[i].
  - Else: X←X−(Y>>>i), Y←Y+(X>>>i), Z←Z−atan[i].
  - All shifts are arithmetic. X and Y update simultaneously from the old values.
  - Z is 16-bit and wraps modulo 2^16.
- **Arctan table** atan[0..15] = 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0.
- **FINISH:** `angle`←Z; `magnitude`←scaled X (see Configuration); `done`←1; `ready`←1.
- **Zero vector:** if x_in=0 and y_in=0 were latched, FINISH forces `angle`=0 and `magnitude`=0. Latency is unchanged.
- **Width bound:** after pre-rotation |X|,|Y| ≤ 32768. Worst-case growth (×1.647·√2 ≈ 76318) fits 19-bit signed, so no saturation logic is needed. Final X is non-negative.
- **Output hold:** `angle` and `magnitude` hold their values until the next FINISH.
- **Ignored start:** `start` is ignored in COMPUTE and FINISH.

## Timing
- Start accepted at edge 0 → iterations at edges 1..16 → FINISH at edge 17.
- `done`=1 and `ready`=1 during the cycle after edge 17. `done` clears at edge 18.
- Latency: 17 clocks from the accepting edge to valid outputs.
- Throughput: a `start` held high at edge 18 is accepted, giving one conversion every 18 clocks. `ready` drops again at that edge.
- `ready` is low from edge 0 through edge 17.
- **Reset mid-conversion:** all outputs return to their reset values immediately (asynchronously). No `done` is issued for the aborted conversion.
- **Input stability:** `x_in`/`y_in` need to be stable only at the accepting edge.

## Configuration
- Macro: `CORDIC_ATAN2_GAIN_COMP_EN`.
- **Defined:** `magnitude` = (X_final × 39797) >> 16. This cancels the CORDIC gain (K≈0.607253), so the result is in input units. One 17×16 multiply is performed in the FINISH cycle.
- **Undefined:** `magnitude` = X_final[16:0], the raw value (≈1.6468× true magnitude). No multiplier is instantiated.
- Angle behaviour and latency are identical in both builds.

## Test plan
Tolerances: angle ±8 LSB modulo 2^16; magnitude ±0.2% or ±3 LSB, whichever is larger. `GAIN_COMP_EN` is defined unless stated otherwise.
- (16384, 0) → `angle`≈0 (accept 65528–8), `magnitude`≈16384. `done` rises exactly 17 clocks after the start edge; `ready` is low throughout.
- (0, 16384), (−16384, 0), (0, −16384) → `angle`≈16384, 32768, 49152; `magnitude`≈16384 each.
- (−32768, −32768) → `angle`≈40960, `magnitude`≈46341; no overflow.
- (0, 0) → `angle`=0, `magnitude`=0, with `done` on schedule. Then `start` held high continuously → a new conversion is accepted every 18 clocks.
- Reset asserted at iteration 8 → `ready`=1, `done`=0, outputs=0 immediately. A `start` pulse during COMPUTE is ignored: exactly one `done` is produced.
- Build without `CORDIC_ATAN2_GAIN_COMP_EN`: (16384, 0) → `magnitude`≈26982 and `angle`≈0; (30000, 30000) → `magnitude`≈69870.

Source files
------------

// File: rtl/cordic_atan2_16bit.sv
// cordic_atan2_16bit: iterative vectoring CORDIC, (x, y) -> angle, magnitude.
// Define CORDIC_ATAN2_GAIN_COMP_EN to scale magnitude back to input units.
module cordic_atan2_16bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  output logic [15:0] angle,
  output logic [16:0] magnitude,
  output logic        done,
  output logic        ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    FINISH  = 2'd2
  } state_t;

  state_t             state;
  logic [3:0]         iter;
  logic signed [18:0] x_r;
  logic signed [18:0] y_r;
  logic signed [18:0] x_sh;
  logic signed [18:0] y_sh;
  logic signed [18:0] x_ext;
  logic signed [18:0] y_ext;
  logic [15:0]        z_r;
  logic [15:0]        atan_c;
  logic               zero_r;
  logic [16:0]        mag_c;

  // sign-extend before any negation so -32768 survives pre-rotation
  assign x_ext = $signed({{3{x_in[15]}}, x_in});
  assign y_ext = $signed({{3{y_in[15]}}, y_in});

  assign x_sh = x_r >>> iter;
  assign y_sh = y_r >>> iter;

  // arctan(2^-i) in 2^16-per-turn units
  always_comb begin
    atan_c = 16'd0;
    unique case (iter)
      4'd0:  atan_c = 16'd8192;
      4'd1:  atan_c = 16'd4836;
      4'd2:  atan_c = 16'd2555;
      4'd3:  atan_c = 16'd1297;
      4'd4:  atan_c = 16'd651;
      4'd5:  atan_c = 16'd326;
      4'd6:  atan_c = 16'd163;
      4'd7:  atan_c = 16'd81;
      4'd8:  atan_c = 16'd41;
      4'd9:  atan_c = 16'd20;
      4'd10: atan_c = 16'd10;
      4'd11: atan_c = 16'd5;
      4'd12: atan_c = 16'd3;
      4'd13: atan_c = 16'd1;
      4'd14: atan_c = 16'd1;
      4'd15: atan_c = 16'd0;
      default: atan_c = 16'd0;
    endcase
  end

`ifdef CORDIC_ATAN2_GAIN_COMP_EN
  // 39797/65536 ~= K, removes the CORDIC gain; final X is non-negative
  assign mag_c = 17'(({16'd0, x_r[16:0]} * 33'd39797) >> 16);
`else
  assign mag_c = x_r[16:0];
`endif

  // control FSM, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      iter      <= 4'd0;
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= 16'd0;
      zero_r    <= 1'b0;
      angle     <= 16'd0;
      magnitude <= 17'd0;
      done      <= 1'b0;
      ready     <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            ready  <= 1'b0;
            iter   <= 4'd0;
            zero_r <= (x_in == 16'd0) && (y_in == 16'd0);
            state  <= COMPUTE;
            if (x_in[15]) begin
              x_r <= -x_ext;
              y_r <= -y_ext;
              z_r <= 16'h8000;
            end else begin
              x_r <= x_ext;
              y_r <= y_ext;
              z_r <= 16'd0;
            end
          end
        end
        COMPUTE: begin
          if (!y_r[18]) begin
            x_r <= x_r + y_sh;
            y_r <= y_r - x_sh;
            z_r <= z_r + atan_c;
          end else begin
            x_r <= x_r - y_sh;
            y_r <= y_r + x_sh;
            z_r <= z_r - atan_c;
          end
          iter <= iter + 4'd1;
          if (iter == 4'd15) state <= FINISH;
        end
        FINISH: begin
          angle     <= zero_r ? 16'd0 : z_r;
          magnitude <= zero_r ? 17'd0 : mag_c;
          done      <= 1'b1;
          ready     <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_atan2_16bit.sv
// tb_cordic_atan2_16bit: directed scoreboard bench for the atan2 CORDIC.
// Expected values come from real-valued atan2/sqrt.
module tb_cordic_atan2_16bit;

  localparam real PI = 3.14159265358979;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] x_in;
  logic [15:0] y_in;
  logic [15:0] angle;
  logic [16:0] magnitude;
  logic        done;
  logic        ready;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string tag;
    int    ang;
    real   mag;
    bit    exact;
  } exp_t;

  exp_t sb[$];

  cordic_atan2_16bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .angle     (angle),
    .magnitude (magnitude),
    .done      (done),
    .ready     (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_ok(input string tag, input bit ok,
                        input int obs, input int exp);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected~%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int x, input int y, input string tag);
    exp_t e;
    real  a;
    real  m;
    e.tag   = tag;
    e.exact = (x == 0) && (y == 0);
    a = e.exact ? 0.0 : $atan2(real'(y), real'(x));
    if (a < 0.0) a = a + 2.0 * PI;
    e.ang = int'(a / (2.0 * PI) * 65536.0) % 65536;
    m = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
`ifndef CORDIC_ATAN2_GAIN_COMP_EN
    m = m * 1.6467602581;
`endif
    e.mag = m;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t              e;
    logic signed [15:0] d16;
    int                sd;
    real               md;
    real               tol;
    chk_eq("sb_nonempty", int'(sb.size() > 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    if (e.exact) begin
      chk_eq({e.tag, "_ang"}, int'(angle), 0);
      chk_eq({e.tag, "_mag"}, int'(magnitude), 0);
    end else begin
      d16 = angle - 16'(e.ang);
      sd  = int'(d16);
      chk_ok({e.tag, "_ang"}, (sd >= -8) && (sd <= 8),
             int'(angle), e.ang);
      md  = real'(magnitude) - e.mag;
      tol = e.mag * 0.002;
      if (tol < 3.0) tol = 3.0;
      chk_ok({e.tag, "_mag"}, (md <= tol) && (md >= -tol),
             int'(magnitude), int'(e.mag));
    end
  endtask

  task automatic convert(input int x, input int y, input string tag);
    int lat;
    bit seen;
    bit rdy_low;
    int w;
    w = 0;
    @(negedge clk);
    while (!ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    x_in  = 16'(x);
    y_in  = 16'(y);
    start = 1'b1;
    push(x, y, tag);
    @(posedge clk);
    #1;
    start = 1'b0;
    x_in  = 16'($urandom);
    y_in  = 16'($urandom);
    lat     = 0;
    seen    = 1'b0;
    rdy_low = 1'b1;
    while (!seen && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (ready) rdy_low = 1'b0;
    end
    chk_eq({tag, "_latency"}, lat, 17);
    chk_eq({tag, "_ready_low"}, int'(rdy_low), 1);
    check_out();
  endtask

  int nd;
  int cyc;
  int dc[3];

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    x_in  = 16'd0;
    y_in  = 16'd0;
    repeat (3) @(negedge clk);
    chk_eq("rst_angle", int'(angle), 0);
    chk_eq("rst_mag", int'(magnitude), 0);
    chk_eq("rst_done", int'(done), 0);
    chk_eq("rst_ready", int'(ready), 1);
    rst_n = 1'b1;

    convert(16384, 0, "px");
    chk_eq("px_done_pulse", int'(done), 1);
    @(negedge clk);
    chk_eq("px_done_clear", int'(done), 0);
    convert(0, 16384, "py");
    convert(-16384, 0, "nx");
    convert(0, -16384, "ny");
    convert(-32768, -32768, "corner");
    convert(30000, 30000, "diag");
    convert(12345, -20000, "q4");
    convert(-7000, 25000, "q2");
    convert(32767, -32768, "edge");
    convert(0, 0, "zero");

    // start held high: back-to-back conversions
    @(negedge clk);
    x_in  = 16'd1000;
    y_in  = 16'd2000;
    start = 1'b1;
    push(1000, 2000, "hold");
    cyc = 0;
    nd  = 0;
    while (nd < 3 && cyc < 80) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done) begin
        dc[nd] = cyc;
        nd++;
        check_out();
        chk_eq("hold_ready", int'(ready), 1);
        if (nd == 3) start = 1'b0;
        else push(1000, 2000, "hold");
      end
    end
    start = 1'b0;
    chk_eq("hold_count", nd, 3);
    chk_eq("hold_first", dc[0], 18);
    chk_eq("hold_gap1", dc[1] - dc[0], 18);
    chk_eq("hold_gap2", dc[2] - dc[1], 18);
    repeat (2) @(negedge clk);
    chk_eq("hold_idle", int'(ready), 1);

    // reset at iteration 8
    @(negedge clk);
    x_in  = 16'd5000;
    y_in  = 16'd7000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("abort_angle", int'(angle), 0);
    chk_eq("abort_mag", int'(magnitude), 0);
    chk_eq("abort_done", int'(done), 0);
    chk_eq("abort_ready", int'(ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk_eq("abort_no_done", nd, 0);

    // start during COMPUTE is ignored
    @(negedge clk);
    x_in  = 16'd20000;
    y_in  = 16'(-5000);
    start = 1'b1;
    push(20000, -5000, "ign");
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    x_in  = 16'(-100);
    y_in  = 16'd100;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nd = 0;
    repeat (45) begin
      @(negedge clk);
      if (done) begin
        nd++;
        check_out();
      end
    end
    chk_eq("ign_one_done", nd, 1);
    chk_eq("ign_ready", int'(ready), 1);
    chk_eq("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
